// File: rtl/pixel_write_sink.sv
// Four-entry pixel write FIFO between pixel producers and a 640x480 1-bit framebuffer.
// Optional range check of incoming pixels is enabled by defining PIXEL_BOUNDS_CHECK_EN.
module pixel_write_sink (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [10:0] in_x,
   input  logic [10:0] in_y,
   input  logic        in_color,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic        mem_data,
   input  logic        mem_ack,
   output logic [2:0]  count,
   output logic        empty,
   output logic [15:0] dropped
);

   localparam int unsigned WIDTH  = 640;
   localparam int unsigned HEIGHT = 480;
   localparam int unsigned DEPTH  = 4;

   typedef struct packed {
      logic [18:0] addr;
      logic        color;
   } entry_t;

   entry_t      fifo_q [DEPTH];
   logic [1:0]  wr_ptr_q;
   logic [1:0]  rd_ptr_q;
   logic [2:0]  count_q;
   logic [18:0] in_addr;
   logic [18:0] y_wide;
   logic        accept;
   logic        push;
   logic        pop;

   assign count    = count_q;
   assign empty    = (count_q == 3'd0);
   assign in_ready = (count_q < 3'(DEPTH));
   assign mem_we   = !empty;

   // Outputs read as zero while idle so nothing stale shows after reset.
   assign mem_addr = mem_we ? fifo_q[rd_ptr_q].addr  : '0;
   assign mem_data = mem_we ? fifo_q[rd_ptr_q].color : 1'b0;

   // y*640 as (y<<9)+(y<<7); the sum wraps to 19 bits.
   assign y_wide  = 19'(in_y);
   assign in_addr = (y_wide << 9) + (y_wide << 7) + 19'(in_x);

   assign accept = in_valid && in_ready;
   assign pop    = mem_we && mem_ack;

`ifdef PIXEL_BOUNDS_CHECK_EN
   logic        in_range;
   logic [15:0] dropped_q;

   assign in_range = (32'(in_x) < WIDTH) && (32'(in_y) < HEIGHT);
   assign push     = accept && in_range;
   assign dropped  = dropped_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         dropped_q <= '0;
      end else if (accept && !in_range && (dropped_q != 16'hFFFF)) begin
         dropped_q <= dropped_q + 16'd1;
      end
   end
`else
   assign push    = accept;
   assign dropped = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: in_addr, color: in_color};
            wr_ptr_q         <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         count_q <= count_q + 3'(push) - 3'(pop);
      end
   end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Scoreboard bench for pixel_write_sink: accepted pixels queue expected writes,
// a monitor pops and compares every framebuffer write.
module tb_pixel_write_sink;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] in_x = '0;
   logic [10:0] in_y = '0;
   logic        in_color = 1'b0;
   logic        mem_we;
   logic [18:0] mem_addr;
   logic        mem_data;
   logic        mem_ack = 1'b0;
   logic [2:0]  count;
   logic        empty;
   logic [15:0] dropped;

   pixel_write_sink dut (
      .clock   (clock),
      .reset   (reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_x    (in_x),
      .in_y    (in_y),
      .in_color(in_color),
      .mem_we  (mem_we),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_ack (mem_ack),
      .count   (count),
      .empty   (empty),
      .dropped (dropped)
   );

   always #5 clock = ~clock;

   typedef struct {
      int addr;
      int color;
   } exp_t;

   exp_t exp_q[$];
   int   exp_dropped = 0;
   int   checks = 0;
   int   errors = 0;
   int   max_count = 0;
   int   n_writes = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: framebuffer address is row*640+col, modulo the 19-bit address space.
   task automatic model_accept(input int x, input int y, input int c);
      exp_t e;
`ifdef PIXEL_BOUNDS_CHECK_EN
      if (x >= 640 || y >= 480) begin
         if (exp_dropped < 65535) exp_dropped++;
         return;
      end
`endif
      e.addr  = (y * 640 + x) % 524288;
      e.color = c;
      exp_q.push_back(e);
   endtask

   // Monitor: checks occupancy-derived outputs and pops on every write.
   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         exp_dropped = 0;
      end else begin
         chk("count", int'(count), exp_q.size());
         chk("empty", int'(empty), int'(exp_q.size() == 0));
         chk("in_ready", int'(in_ready), int'(exp_q.size() < 4));
         chk("mem_we", int'(mem_we), int'(exp_q.size() != 0));
         chk("dropped", int'(dropped), exp_dropped);
         if (int'(count) > max_count) max_count = int'(count);
         if (mem_we && mem_ack) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("mem_addr", int'(mem_addr), e.addr);
               chk("mem_data", int'(mem_data), e.color);
            end
         end
      end
   end

   // Acceptance observer: feeds the reference model after the monitor has run.
   always @(negedge clock) begin
      #1;
      if (!reset && in_valid && in_ready) model_accept(int'(in_x), int'(in_y), int'(in_color));
   end

   // All tasks start and end at posedge+1.
   task automatic send(input int x, input int y, input int c);
      int n = 0;
      in_valid = 1'b1;
      in_x     = 11'(x);
      in_y     = 11'(y);
      in_color = c[0];
      @(negedge clock);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clock);
      end
      if (n >= 100) chk("send_timeout", 1, 0);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_dropped", int'(dropped), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_mem_data", int'(mem_data), 0);
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      mem_ack = 1'b1;
      while (!empty && n < 50) begin
         n++;
         @(posedge clock);
         #1;
      end
      if (n >= 50) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      int base;
      logic acc;

      @(posedge clock);
      #1;
      do_reset();

      // First pixel appears the cycle after accept, then drains.
      mem_ack = 1'b1;
      send(0, 0, 1);
      @(negedge clock);
      chk("lat_mem_we", int'(mem_we), 1);
      chk("lat_mem_addr", int'(mem_addr), 0);
      chk("lat_mem_data", int'(mem_data), 1);
      @(negedge clock);
      chk("lat_empty_after", int'(empty), 1);
      @(posedge clock);
      #1;

      send(639, 479, 0);
      send(5, 2, 1);
      drain();

      // Backpressure: four fill, fifth waits, drains in order.
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) send(10 + i, 3, i % 2);
      chk("full_count", int'(count), 4);
      chk("full_in_ready", int'(in_ready), 0);
      in_valid = 1'b1;
      in_x     = 11'd20;
      in_y     = 11'd3;
      in_color = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("held_count", int'(count), 4);
      mem_ack = 1'b1;
      @(negedge clock);
      chk("ready_before_pop", int'(in_ready), 0);
      @(negedge clock);
      chk("ready_after_pop", int'(in_ready), 1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      drain();

      // Out-of-range pixels: dropped with the range check, wrapped-free writes without.
      do_reset();
      mem_ack = 1'b1;
      send(640, 0, 1);
      send(0, 480, 0);
      drain();
      @(negedge clock);
`ifdef PIXEL_BOUNDS_CHECK_EN
      chk("bounds_dropped", int'(dropped), 2);
`else
      chk("bounds_dropped", int'(dropped), 0);
`endif
      @(posedge clock);
      #1;

      // Reset with three queued entries: none may be written afterwards.
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) send(100 + i, 7, 1);
      chk("pre_reset_count", int'(count), 3);
      base = n_writes;
      do_reset();
      mem_ack = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      chk("post_reset_writes", n_writes - base, 0);

      // Raster stream over the first rows with mem_ack held high.
      max_count = 0;
      base = n_writes;
      for (int y = 0; y < 40; y++)
         for (int x = 0; x < 640; x++) send(x, y, (x ^ y) & 1);
      drain();
      chk("stream_writes", n_writes - base, 640 * 40);
      chk("stream_max_count_le1", int'(max_count <= 1), 1);

      // Random traffic including out-of-range and truncating coordinates.
      acc = 1'b0;
      repeat (4000) begin
         @(negedge clock);
         acc = in_valid && in_ready;
         @(posedge clock);
         #1;
         if (!in_valid || acc) begin
            in_valid = ($urandom % 4) != 0;
            if ($urandom % 8 == 0) begin
               in_x = 11'($urandom_range(0, 2047));
               in_y = 11'($urandom_range(0, 2047));
            end else begin
               in_x = 11'($urandom_range(0, 700));
               in_y = 11'($urandom_range(0, 520));
            end
            in_color = 1'($urandom % 2);
         end
         mem_ack = 1'($urandom % 2);
      end
      @(negedge clock);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      drain();
      @(negedge clock);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_write_sink.md
PIXEL_WRITE_SINK -- requirements
Module: pixel_write_sink

Interface
REQ-001 The block SHALL have these ports: clock  input  1  system clock, all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 in_valid  input  1  producer offers a pixel write (clearer, line drawer).
REQ-004 in_ready  output  1  sink can accept a pixel this cycle.
REQ-005 in_x  input  11  pixel column.
REQ-006 in_y  input  11  pixel row.
REQ-007 in_color  input  1  pixel value.
REQ-008 mem_we  output  1  framebuffer write request.
REQ-009 mem_addr  output  19  framebuffer word address.
REQ-010 mem_data  output  1  framebuffer write data.
REQ-011 mem_ack  input  1  framebuffer accepts the current write this cycle.
REQ-012 count  output  3  FIFO occupancy, 0..4.
REQ-013 empty  output  1  high when count == 0.
REQ-014 dropped  output  16  out-of-range pixel counter (see Configuration).

Function
REQ-015 Parameters SHALL be WIDTH = 640, HEIGHT = 480, DEPTH = 4, where WIDTH is the line pitch, HEIGHT is the row count and DEPTH is the FIFO entry count.
REQ-016 Accept SHALL occur on a cycle with in_valid && in_ready.
REQ-017 in_ready SHALL be a function of registered occupancy only: in_ready = (count < 4), with no combinational path from mem_ack.
REQ-018 The address SHALL be computed at accept as mem_addr = in_y*640 + in_x.
  - Computed as (y<<9) + (y<<7) + x.
  - Truncated to 19 bits.
  - Stored in the FIFO entry with in_color.
REQ-019 The FIFO SHALL be 4 entries, first-in first-out, with 2-bit read and write pointers that wrap 3 -> 0.
REQ-020 mem_we SHALL equal (count != 0); mem_addr and mem_data SHALL present the head entry whenever mem_we is high.
REQ-021 Pop SHALL occur on a cycle with mem_we && mem_ack, advancing the head on that edge.
REQ-022 mem_addr and mem_data SHALL hold stable while mem_we is high and mem_ack is low.
REQ-023 Latency: a pixel accepted at edge N into an empty FIFO SHALL appear on mem_we, mem_addr and mem_data in the cycle following edge N.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and preserve order; this is legal for count 1..3.
REQ-025 A push with count == 0 and a pop SHALL be impossible, because mem_we is low.
REQ-026 At count == 4, in_ready SHALL be low; a pop that cycle SHALL make in_ready high in the next cycle.
REQ-027 in_valid SHALL be ignored while in_ready is low; the producer holds its data.
REQ-028 The mem_ack value SHALL be ignored while mem_we is low.

Reset
REQ-029 On a reset edge the block SHALL clear the pointers and count to 0, so that in the next cycle:
  - empty = 1;
  - mem_we = 0;
  - in_ready = 1;
  - dropped = 0;
  - mem_addr and mem_data = 0.
REQ-030 Reset mid-operation SHALL discard all queued entries without writing them; an accept or pop coincident with reset SHALL have no effect.

Configuration
REQ-031 Macro PIXEL_BOUNDS_CHECK_EN, when defined, SHALL enable the following handling of a pixel with in_x >= 640 or in_y >= 480:
  - The pixel is accepted (handshake completes) but not enqueued.
  - dropped increments by 1 and saturates at 65535.
  - count is unchanged by that accept.
REQ-032 Without PIXEL_BOUNDS_CHECK_EN, no range check SHALL be made, every accepted pixel SHALL be enqueued with its truncated address, and dropped SHALL be tied to 0.

Verification
REQ-033 After reset, accept (x=0, y=0, c=1) with mem_ack held 1 -> next cycle mem_we = 1, mem_addr = 0, mem_data = 1; the cycle after, empty = 1.
REQ-034 Accept (639, 479, 0) -> mem_addr = 307199; accept (5, 2, 1) -> mem_addr = 1285.
REQ-035 mem_ack held 0, push 5 consecutive pixels -> count reaches 4; in_ready = 0 after the 4th accept; the 5th is held; raising mem_ack drains pixels in order; the 5th is accepted the cycle after the first pop.
REQ-036 Continuous in_valid with mem_ack = 1 streaming the full 640x480 raster -> 307200 writes, addresses 0..307199 in order, count never exceeds 1.
REQ-037 With PIXEL_BOUNDS_CHECK_EN, accept (640, 0) and (0, 480) -> no mem_we, dropped = 2; without the macro -> both are written, at addresses 640 and 307200.
REQ-038 Three entries queued with mem_ack = 0, then reset -> next cycle count = 0, mem_we = 0, in_ready = 1; no queued pixel is ever written.
